// File: rtl/axis_i2c_target.sv
// I2C target: synchronises SCL/SDA, decodes START/STOP, matches a 7-bit
// address, streams written bytes to an AXIS master port and shifts bytes
// from an AXIS slave port onto SDA for reads. Open-drain SDA, no stretching.
module axis_i2c_target #(
  parameter int         I2C_DATA_WIDTH = 8,
  parameter logic [6:0] DEV_ADDR       = 7'h50
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe_o,
  output logic [I2C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [I2C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int W  = I2C_DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] RELOAD = CW'(W - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, ACK_RD
  } state_t;

  // synchronisers plus one delayed copy for edge detection
  logic scl_s1, scl_s2, scl_q;
  logic sda_s1, sda_s2, sda_q;
  logic scl_rise, scl_fall, start_c, stop_c;

  state_t        state, state_n;
  logic [W-1:0]  shreg, shreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rw, rw_n;
  logic          phase, phase_n;   // second half of an ACK slot
  logic          ack_ok, ack_ok_n; // ACK to send (write) / ACK seen (read)
  logic          oe, oe_n;
  logic [W-1:0]  tdata, tdata_n;
  logic          tvalid, tvalid_n;
  logic          tready_p, tready_p_n;
  logic          err, err_n;
  logic          load;
  logic          tv_busy;
  logic [W-1:0]  shift_in;

  // two-stage synchronisers, preset high (idle bus level)
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_q <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_q <= 1'b1;
    end else begin
      scl_s1 <= scl_i;  scl_s2 <= scl_s1; scl_q <= scl_s2;
      sda_s1 <= sda_i;  sda_s2 <= sda_s1; sda_q <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_q;
  assign scl_fall = ~scl_s2 & scl_q;
  assign start_c  = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop_c   = scl_s2 & scl_q & ~sda_q & sda_s2;

  // a byte still waiting downstream that is not being accepted this cycle
  assign tv_busy  = tvalid & ~m_axis_tready;
  assign shift_in = {shreg[W-2:0], sda_s2};

  // next-state and datapath decode
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    rw_n       = rw;
    phase_n    = phase;
    ack_ok_n   = ack_ok;
    oe_n       = oe;
    tdata_n    = tdata;
    tvalid_n   = tvalid;
    tready_p_n = 1'b0;
    err_n      = 1'b0;
    load       = 1'b0;

    // accept clears first, so a byte completing in the same cycle fits
    if (tvalid && m_axis_tready) tvalid_n = 1'b0;

    if (start_c) begin
      state_n = ADDR;
      cnt_n   = RELOAD;
      oe_n    = 1'b0;
      phase_n = 1'b0;
    end else if (stop_c) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      phase_n = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shreg_n = shift_in;
          cnt_n   = cnt - 1'b1;
          if (cnt == '0) begin
            if (shift_in[W-1:W-7] == DEV_ADDR) begin
              state_n = ACK_ADDR;
              rw_n    = sda_s2;
              phase_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        ACK_ADDR: if (scl_fall) begin
          if (!phase) begin
            oe_n    = 1'b1;
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            cnt_n   = RELOAD;
            if (rw) begin
              load = 1'b1;
            end else begin
              oe_n    = 1'b0;
              state_n = WR_DATA;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_n = shift_in;
          cnt_n   = cnt - 1'b1;
          if (cnt == '0) begin
            state_n = ACK_WR;
            phase_n = 1'b0;
            if (!tv_busy) begin
              tdata_n  = shift_in;
              tvalid_n = 1'b1;
              ack_ok_n = 1'b1;
            end else begin
              err_n    = 1'b1;
              ack_ok_n = 1'b0;
            end
          end
        end
        ACK_WR: if (scl_fall) begin
          if (!phase) begin
            oe_n    = ack_ok;
            phase_n = 1'b1;
          end else begin
            oe_n    = 1'b0;
            phase_n = 1'b0;
            cnt_n   = RELOAD;
            state_n = WR_DATA;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (cnt == '0) begin
            oe_n    = 1'b0;
            state_n = ACK_RD;
          end else begin
            shreg_n = {shreg[W-2:0], 1'b0};
            oe_n    = ~shreg[W-2];
            cnt_n   = cnt - 1'b1;
          end
        end
        ACK_RD: begin
          if (scl_rise) ack_ok_n = ~sda_s2;
          if (scl_fall) begin
            if (ack_ok) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
              oe_n    = 1'b0;
            end
          end
        end
        default: state_n = IDLE;
      endcase

      // transmit byte fetch, shared by address ACK and master ACK
      if (load) begin
        state_n = RD_DATA;
        cnt_n   = RELOAD;
        if (s_axis_tvalid) begin
          shreg_n    = s_axis_tdata;
          oe_n       = ~s_axis_tdata[W-1];
          tready_p_n = 1'b1;
        end else begin
          shreg_n = '1;
          oe_n    = 1'b0;
          err_n   = 1'b1;
        end
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      rw       <= 1'b0;
      phase    <= 1'b0;
      ack_ok   <= 1'b0;
      oe       <= 1'b0;
      tdata    <= '0;
      tvalid   <= 1'b0;
      tready_p <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      cnt      <= cnt_n;
      rw       <= rw_n;
      phase    <= phase_n;
      ack_ok   <= ack_ok_n;
      oe       <= oe_n;
      tdata    <= tdata_n;
      tvalid   <= tvalid_n;
      tready_p <= tready_p_n;
      err      <= err_n;
    end
  end

  assign sda_oe_o      = oe;
  assign m_axis_tdata  = tdata;
  assign m_axis_tvalid = tvalid;
  assign s_axis_tready = tready_p;
  assign busy_o        = (state != IDLE);
  assign err_o         = err;

endmodule

// File: tb/tb_axis_i2c_target.sv
// Directed bench for axis_i2c_target: a bit-banged I2C master with a
// wired-AND SDA bus, AXIS source/sink models and event counters.
module tb_axis_i2c_target;

  localparam int Q = 10; // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic       sda_bus;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       busy;
  logic       err;

  logic [7:0] src [0:3];
  int         src_n = 0;
  int         src_base = 0;

  int         beats = 0, rdy_cnt = 0, err_cnt = 0, oe_cnt = 0;
  logic [7:0] last_data = 8'h00;
  int         tv_lat = -1;
  time        rise_t = 0;
  logic       tv_q = 1'b0;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  assign sda_bus  = sda_m & ~sda_oe;
  assign s_tvalid = (rdy_cnt - src_base) < src_n;
  assign s_tdata  = src[2'(rdy_cnt - src_base)];

  axis_i2c_target dut (
    .clk_i         (clk),
    .arst_i        (arst),
    .scl_i         (scl_m),
    .sda_i         (sda_bus),
    .sda_oe_o      (sda_oe),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .busy_o        (busy),
    .err_o         (err)
  );

  // event counters sampled mid-cycle
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      beats     <= beats + 1;
      last_data <= m_tdata;
    end
    if (s_tready) rdy_cnt <= rdy_cnt + 1;
    if (err)      err_cnt <= err_cnt + 1;
    if (sda_oe)   oe_cnt  <= oe_cnt + 1;
    if (m_tvalid && !tv_q) tv_lat <= int'(($time - rise_t) / 10);
    tv_q <= m_tvalid;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;
    wq(Q);
    scl_m  = 1'b1;
    rise_t = $time;
    wq(Q);
    r = sda_bus;
    wq(Q);
    scl_m = 1'b0;
    wq(Q);
  endtask

  task automatic start_c();
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(mack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] rb;
    int         b0, e0, t0, o0;

    // reset state
    wq(5);
    chk("rst_oe",     int'(sda_oe),   0);
    chk("rst_tvalid", int'(m_tvalid), 0);
    chk("rst_tdata",  int'(m_tdata),  0);
    chk("rst_tready", int'(s_tready), 0);
    chk("rst_busy",   int'(busy),     0);
    chk("rst_err",    int'(err),      0);
    arst = 1'b0;
    wq(5);

    // 1: write 0x3C to 0x50
    m_tready = 1'b1;
    b0 = beats;
    start_c();
    wr_byte(8'hA0, ack); chk("t1_ack_addr", int'(ack), 0);
    chk("t1_busy", int'(busy), 1);
    wr_byte(8'h3C, ack); chk("t1_ack_data", int'(ack), 0);
    stop_c();
    wq(5);
    chk("t1_beats", beats - b0, 1);
    chk("t1_data",  int'(last_data), 8'h3C);
    chk("t1_idle",  int'(busy), 0);

    // 2: wrong address 0x51
    b0 = beats; o0 = oe_cnt;
    start_c();
    wr_byte(8'hA2, ack); chk("t2_ack_addr", int'(ack), 1);
    chk("t2_busy", int'(busy), 0);
    wr_byte(8'h77, ack); chk("t2_ack_data", int'(ack), 1);
    stop_c();
    wq(5);
    chk("t2_oe_cnt", oe_cnt - o0, 0);
    chk("t2_beats",  beats - b0, 0);

    // 3: read 0x96, 0x5A
    src[0] = 8'h96; src[1] = 8'h5A;
    src_base = rdy_cnt; src_n = 2;
    t0 = rdy_cnt; e0 = err_cnt;
    start_c();
    wr_byte(8'hA1, ack); chk("t3_ack_addr", int'(ack), 0);
    rd_byte(1'b0, rb);   chk("t3_byte0", int'(rb), 8'h96);
    rd_byte(1'b1, rb);   chk("t3_byte1", int'(rb), 8'h5A);
    stop_c();
    wq(5);
    chk("t3_tready_pulses", rdy_cnt - t0, 2);
    chk("t3_err", err_cnt - e0, 0);
    chk("t3_idle", int'(busy), 0);

    // 4: overrun with tready low
    m_tready = 1'b0;
    b0 = beats; e0 = err_cnt;
    start_c();
    wr_byte(8'hA0, ack); chk("t4_ack_addr", int'(ack), 0);
    wr_byte(8'h11, ack); chk("t4_ack_11", int'(ack), 0);
    chk("t4_tvalid_lat", tv_lat, 3);
    wr_byte(8'h22, ack); chk("t4_nack_22", int'(ack), 1);
    stop_c();
    wq(5);
    chk("t4_err", err_cnt - e0, 1);
    chk("t4_hold_valid", int'(m_tvalid), 1);
    chk("t4_hold_data",  int'(m_tdata), 8'h11);
    m_tready = 1'b1;
    wq(3);
    chk("t4_beats", beats - b0, 1);
    chk("t4_drain_data", int'(last_data), 8'h11);
    chk("t4_cleared", int'(m_tvalid), 0);

    // 5: read underrun
    src_base = rdy_cnt; src_n = 0;
    t0 = rdy_cnt; e0 = err_cnt;
    start_c();
    wr_byte(8'hA1, ack); chk("t5_ack_addr", int'(ack), 0);
    rd_byte(1'b1, rb);   chk("t5_byte", int'(rb), 8'hFF);
    stop_c();
    wq(5);
    chk("t5_err", err_cnt - e0, 1);
    chk("t5_tready_pulses", rdy_cnt - t0, 0);

    // 6: repeated START mid-write, then reset mid-byte
    m_tready = 1'b0;
    start_c();
    wr_byte(8'hA0, ack); chk("t6_ack_addr0", int'(ack), 0);
    bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b0, r);
    start_c();
    wr_byte(8'hA0, ack); chk("t6_ack_rs", int'(ack), 0);
    wr_byte(8'h5C, ack); chk("t6_ack_5c", int'(ack), 0);
    chk("t6_pending", int'(m_tvalid), 1);
    chk("t6_pending_data", int'(m_tdata), 8'h5C);
    bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b1, r);
    arst = 1'b1;
    wq(2);
    chk("t6_rst_oe",     int'(sda_oe),   0);
    chk("t6_rst_tvalid", int'(m_tvalid), 0);
    chk("t6_rst_busy",   int'(busy),     0);
    chk("t6_rst_err",    int'(err),      0);
    chk("t6_rst_tready", int'(s_tready), 0);
    chk("t6_rst_bus",    int'(sda_bus),  int'(sda_m));
    arst = 1'b0;
    wq(5);
    stop_c();
    m_tready = 1'b1;
    b0 = beats;
    start_c();
    wr_byte(8'hA0, ack); chk("t6_ack_after_rst", int'(ack), 0);
    wr_byte(8'h33, ack); chk("t6_ack_33", int'(ack), 0);
    stop_c();
    wq(5);
    chk("t6_beats", beats - b0, 1);
    chk("t6_data", int'(last_data), 8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
